// File: rtl/reg_bank_pkg.sv
// ---------------------------------------------------------------------------
// reg_bank_pkg
// Shared definitions for the architectural register bank: the 32-bit word
// type, the register index type and the named indices of the special
// registers (stack pointer, link register, program counter).
// Configuration macro used by the bank: REG_BANK_PC_INC_EN.
// ---------------------------------------------------------------------------
package reg_bank_pkg;

  localparam int WORD_W   = 32;
  localparam int NUM_REGS = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [3:0]        reg_idx_t;

  localparam reg_idx_t REG_SP = 4'd13;
  localparam reg_idx_t REG_LR = 4'd14;
  localparam reg_idx_t REG_PC = 4'd15;

  // True when a general write in this cycle targets the given register.
  function automatic logic writeHits(input logic regWrite,
                                     input reg_idx_t writeRegister,
                                     input reg_idx_t target);
    return regWrite && (writeRegister == target);
  endfunction

endpackage

// File: rtl/reg_bank_if.sv
// ---------------------------------------------------------------------------
// reg_bank_if
// Bundles the register bank's write ports and its register outputs.
//   master : datapath side, drives writes and pcAdvance, observes registers
//   slave  : the bank itself
// Signals:
//   regWrite/writeRegister/writeData : general write port
//   linkWrite/linkData               : branch-with-link write into R14
//   pcAdvance                        : R15 sequencing request
//   regupdate_R0..regupdate_R15      : current register contents
//   pcWritten                        : R15 was loaded by the general port
// ---------------------------------------------------------------------------
interface reg_bank_if;
  import reg_bank_pkg::*;

  logic     regWrite;
  reg_idx_t writeRegister;
  word_t    writeData;
  logic     linkWrite;
  word_t    linkData;
  logic     pcAdvance;

  word_t regupdate_R0;
  word_t regupdate_R1;
  word_t regupdate_R2;
  word_t regupdate_R3;
  word_t regupdate_R4;
  word_t regupdate_R5;
  word_t regupdate_R6;
  word_t regupdate_R7;
  word_t regupdate_R8;
  word_t regupdate_R9;
  word_t regupdate_R10;
  word_t regupdate_R11;
  word_t regupdate_R12;
  word_t regupdate_R13;
  word_t regupdate_R14;
  word_t regupdate_R15;
  logic  pcWritten;

  modport master (
    output regWrite, writeRegister, writeData, linkWrite, linkData, pcAdvance,
    input  regupdate_R0, regupdate_R1, regupdate_R2, regupdate_R3,
           regupdate_R4, regupdate_R5, regupdate_R6, regupdate_R7,
           regupdate_R8, regupdate_R9, regupdate_R10, regupdate_R11,
           regupdate_R12, regupdate_R13, regupdate_R14, regupdate_R15,
           pcWritten
  );

  modport slave (
    input  regWrite, writeRegister, writeData, linkWrite, linkData, pcAdvance,
    output regupdate_R0, regupdate_R1, regupdate_R2, regupdate_R3,
           regupdate_R4, regupdate_R5, regupdate_R6, regupdate_R7,
           regupdate_R8, regupdate_R9, regupdate_R10, regupdate_R11,
           regupdate_R12, regupdate_R13, regupdate_R14, regupdate_R15,
           pcWritten
  );

endinterface

// File: rtl/reg_bank_cell.sv
// ---------------------------------------------------------------------------
// reg_cell
// One 32-bit architectural register with load enable and a per-instance
// reset value.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous, active-low
//   loadEn_i : load d_i on the next edge
//   d_i      : next value
//   q_o      : current value
// ---------------------------------------------------------------------------
module reg_cell
  import reg_bank_pkg::*;
#(
  parameter word_t RESET_VAL = '0
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  loadEn_i,
  input  word_t d_i,
  output word_t q_o
);

  word_t data_q;

  // Reset wins over a load presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= RESET_VAL;
    end else if (loadEn_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_bank.sv
// ---------------------------------------------------------------------------
// reg_bank
// Sixteen 32-bit architectural registers R0..R15 with one general write
// port, a dedicated link-register write into R14 and program-counter
// sequencing on R15. All register values are presented continuously.
// Parameters:
//   RESET_PC : R15 value after reset
//   PC_STEP  : R15 increment per advancing cycle
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   bus   : reg_bank_if.slave (write ports, register outputs, pcWritten)
// Configuration:
//   REG_BANK_PC_INC_EN defined   -> pcAdvance increments R15
//   REG_BANK_PC_INC_EN undefined -> pcAdvance is ignored
// ---------------------------------------------------------------------------
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000,
  parameter word_t PC_STEP  = 32'd4
) (
  input logic      clk,
  input logic      reset,
  reg_bank_if.slave bus
);

`ifdef REG_BANK_PC_INC_EN
  localparam logic PcIncEn = 1'b1;
`else
  localparam logic PcIncEn = 1'b0;
`endif

  logic [NUM_REGS-1:0] loadEn;
  word_t               regD [NUM_REGS];
  word_t               regQ [NUM_REGS];

  logic lrGenWrite;
  logic pcGenWrite;
  logic pcStep;
  logic pcWritten_d;
  logic pcWritten_q;

  assign lrGenWrite = writeHits(bus.regWrite, bus.writeRegister, REG_LR);
  assign pcGenWrite = writeHits(bus.regWrite, bus.writeRegister, REG_PC);
  assign pcStep     = PcIncEn && bus.pcAdvance;

  // Next-value selection. The general port always wins; the link write and
  // the PC increment only fill in when the general port targets elsewhere.
  always_comb begin
    loadEn = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regD[i] = bus.writeData;
    end

    if (bus.regWrite) begin
      loadEn[bus.writeRegister] = 1'b1;
    end

    if (bus.linkWrite && !lrGenWrite) begin
      loadEn[REG_LR] = 1'b1;
      regD[REG_LR]   = bus.linkData;
    end

    // 32-bit addition wraps naturally at the top of the address space.
    if (pcStep && !pcGenWrite) begin
      loadEn[REG_PC] = 1'b1;
      regD[REG_PC]   = regQ[REG_PC] + PC_STEP;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : gCell
    reg_cell #(
      .RESET_VAL((g == NUM_REGS - 1) ? RESET_PC : word_t'(0))
    ) uCell (
      .clk      (clk),
      .reset    (reset),
      .loadEn_i (loadEn[g]),
      .d_i      (regD[g]),
      .q_o      (regQ[g])
    );
  end

  // pcWritten only reflects loads through the general port, never increments.
  assign pcWritten_d = pcGenWrite;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pcWritten_q <= 1'b0;
    end else begin
      pcWritten_q <= pcWritten_d;
    end
  end

  assign bus.pcWritten     = pcWritten_q;
  assign bus.regupdate_R0  = regQ[0];
  assign bus.regupdate_R1  = regQ[1];
  assign bus.regupdate_R2  = regQ[2];
  assign bus.regupdate_R3  = regQ[3];
  assign bus.regupdate_R4  = regQ[4];
  assign bus.regupdate_R5  = regQ[5];
  assign bus.regupdate_R6  = regQ[6];
  assign bus.regupdate_R7  = regQ[7];
  assign bus.regupdate_R8  = regQ[8];
  assign bus.regupdate_R9  = regQ[9];
  assign bus.regupdate_R10 = regQ[10];
  assign bus.regupdate_R11 = regQ[11];
  assign bus.regupdate_R12 = regQ[12];
  assign bus.regupdate_R13 = regQ[13];
  assign bus.regupdate_R14 = regQ[14];
  assign bus.regupdate_R15 = regQ[15];

endmodule

// File: tb/tb_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_reg_bank
// Self-checking bench for reg_bank (RESET_PC = 32'h100). A directed table
// walks the documented scenarios, then a short hand sequence and a random
// run are compared against an array-based model of the register file.
// Honours REG_BANK_PC_INC_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_reg_bank;
  import reg_bank_pkg::*;

`ifdef REG_BANK_PC_INC_EN
  localparam logic PcIncEn = 1'b1;
`else
  localparam logic PcIncEn = 1'b0;
`endif

  localparam word_t TbResetPc = 32'h0000_0100;
  localparam word_t Step      = PcIncEn ? 32'd4 : 32'd0;

  typedef struct {
    logic     rst;
    logic     wr;
    reg_idx_t idx;
    word_t    data;
    logic     lw;
    word_t    ld;
    logic     adv;
    reg_idx_t expIdx;
    word_t    expVal;
    logic     expPcW;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  reg_bank_if bus ();

  reg_bank #(
    .RESET_PC (TbResetPc),
    .PC_STEP  (32'd4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  word_t mReg [16];
  logic  mPcW;

  function automatic word_t getReg(input int i);
    case (i)
      0:  return bus.regupdate_R0;
      1:  return bus.regupdate_R1;
      2:  return bus.regupdate_R2;
      3:  return bus.regupdate_R3;
      4:  return bus.regupdate_R4;
      5:  return bus.regupdate_R5;
      6:  return bus.regupdate_R6;
      7:  return bus.regupdate_R7;
      8:  return bus.regupdate_R8;
      9:  return bus.regupdate_R9;
      10: return bus.regupdate_R10;
      11: return bus.regupdate_R11;
      12: return bus.regupdate_R12;
      13: return bus.regupdate_R13;
      14: return bus.regupdate_R14;
      default: return bus.regupdate_R15;
    endcase
  endfunction

  // Reference behaviour: start from the old contents, apply the lower
  // priority updates, then let the general write overwrite its target.
  task automatic modelStep(input vec_t v);
    word_t nxt [16];
    if (!v.rst) begin
      for (int i = 0; i < 15; i++) mReg[i] = '0;
      mReg[15] = TbResetPc;
      mPcW = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) nxt[i] = mReg[i];
      if (v.lw) nxt[14] = v.ld;
      if (PcIncEn && v.adv) nxt[15] = mReg[15] + 32'd4;
      if (v.wr) nxt[v.idx] = v.data;
      for (int i = 0; i < 16; i++) mReg[i] = nxt[i];
      mPcW = v.wr && (v.idx == 4'd15);
    end
  endtask

  task automatic checkOutput(input string tag);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (getReg(i) !== mReg[i]) begin
        failures++;
        $display("[TB] FAIL %s R%0d got=%h exp=%h", tag, i, getReg(i), mReg[i]);
      end
    end
    checks++;
    if (bus.pcWritten !== mPcW) begin
      failures++;
      $display("[TB] FAIL %s pcWritten got=%b exp=%b", tag, bus.pcWritten, mPcW);
    end
  endtask

  // Drive one cycle from the falling edge, update the model at the rising
  // edge, and compare on the next falling edge.
  task automatic applyStimulus(input vec_t v, input string tag);
    reset             = v.rst;
    bus.regWrite      = v.wr;
    bus.writeRegister = v.idx;
    bus.writeData     = v.data;
    bus.linkWrite     = v.lw;
    bus.linkData      = v.ld;
    bus.pcAdvance     = v.adv;
    @(posedge clk);
    modelStep(v);
    @(negedge clk);
    checkOutput(tag);
  endtask

  function automatic vec_t mk(input logic rst, input logic wr, input reg_idx_t idx,
                              input word_t data, input logic lw, input word_t ld,
                              input logic adv, input reg_idx_t expIdx,
                              input word_t expVal, input logic expPcW);
    vec_t v;
    v.rst = rst; v.wr = wr; v.idx = idx; v.data = data;
    v.lw = lw; v.ld = ld; v.adv = adv;
    v.expIdx = expIdx; v.expVal = expVal; v.expPcW = expPcW;
    return v;
  endfunction

  vec_t vecs [15];

  initial begin
    vec_t v;

    reset             = 1'b1;
    bus.regWrite      = 1'b0;
    bus.writeRegister = '0;
    bus.writeData     = '0;
    bus.linkWrite     = 1'b0;
    bus.linkData      = '0;
    bus.pcAdvance     = 1'b0;

    //           rst wr  idx    data           lw  ld      adv  expIdx expVal                            pcW
    vecs[0]  = mk(0, 0, 4'd0,  32'h0,         0, 32'h0,  0,   4'd15, TbResetPc,                        0);
    vecs[1]  = mk(1, 1, 4'd3,  32'hCCCC_CCCC, 0, 32'h0,  0,   4'd3,  32'hCCCC_CCCC,                    0);
    vecs[2]  = mk(1, 0, 4'd0,  32'h0,         0, 32'h0,  1,   4'd15, 32'h100 + Step,                   0);
    vecs[3]  = mk(1, 0, 4'd0,  32'h0,         0, 32'h0,  1,   4'd15, 32'h100 + 2 * Step,               0);
    vecs[4]  = mk(1, 0, 4'd0,  32'h0,         0, 32'h0,  1,   4'd15, 32'h100 + 3 * Step,               0);
    vecs[5]  = mk(1, 1, 4'd15, 32'h2000,      0, 32'h0,  1,   4'd15, 32'h2000,                         1);
    vecs[6]  = mk(1, 0, 4'd0,  32'h0,         0, 32'h0,  0,   4'd15, 32'h2000,                         0);
    vecs[7]  = mk(1, 1, 4'd14, 32'h55,        1, 32'h44, 0,   4'd14, 32'h55,                           0);
    vecs[8]  = mk(1, 1, 4'd2,  32'h55,        1, 32'h44, 0,   4'd14, 32'h44,                           0);
    vecs[9]  = mk(1, 0, 4'd0,  32'h0,         0, 32'h0,  0,   4'd2,  32'h55,                           0);
    vecs[10] = mk(1, 1, 4'd15, 32'hFFFF_FFFC, 0, 32'h0,  0,   4'd15, 32'hFFFF_FFFC,                    1);
    vecs[11] = mk(1, 0, 4'd0,  32'h0,         0, 32'h0,  1,   4'd15, PcIncEn ? 32'h0 : 32'hFFFF_FFFC,  0);
    vecs[12] = mk(1, 1, 4'd5,  32'h1111_1111, 0, 32'h0,  0,   4'd5,  32'h1111_1111,                    0);
    vecs[13] = mk(0, 1, 4'd5,  32'hAAAA_AAAA, 0, 32'h0,  1,   4'd5,  32'h0,                            0);
    vecs[14] = mk(1, 1, 4'd5,  32'h1234_5678, 0, 32'h0,  0,   4'd5,  32'h1234_5678,                    0);

    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      checks++;
      if (getReg(vecs[i].expIdx) !== vecs[i].expVal) begin
        failures++;
        $display("[TB] FAIL vec%0d table R%0d got=%h exp=%h", i, vecs[i].expIdx,
                 getReg(vecs[i].expIdx), vecs[i].expVal);
      end
      checks++;
      if (bus.pcWritten !== vecs[i].expPcW) begin
        failures++;
        $display("[TB] FAIL vec%0d table pcWritten got=%b exp=%b", i,
                 bus.pcWritten, vecs[i].expPcW);
      end
    end

    // Back-to-back R15 writes keep pcWritten high, then it drops after one
    // idle cycle.
    applyStimulus(mk(1, 1, 4'd15, 32'h3000, 0, 32'h0, 1, 4'd15, 32'h3000, 1), "pcw1");
    applyStimulus(mk(1, 1, 4'd15, 32'h4000, 0, 32'h0, 0, 4'd15, 32'h4000, 1), "pcw2");
    checks++;
    if (bus.pcWritten !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pcw2 hold got=%b exp=1", bus.pcWritten);
    end
    applyStimulus(mk(1, 1, 4'd7, 32'h7777, 0, 32'h0, 1, 4'd7, 32'h7777, 0), "pcw3");
    checks++;
    if (bus.pcWritten !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pcw3 drop got=%b exp=0", bus.pcWritten);
    end

    // Random traffic with occasional resets and writes near the PC wrap.
    for (int n = 0; n < 400; n++) begin
      v.rst    = ($urandom_range(0, 24) != 0);
      v.wr     = $urandom_range(0, 1) == 1;
      v.idx    = reg_idx_t'($urandom_range(0, 15));
      v.data   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : word_t'($urandom);
      v.lw     = $urandom_range(0, 2) == 0;
      v.ld     = word_t'($urandom);
      v.adv    = $urandom_range(0, 4) != 0;
      v.expIdx = '0;
      v.expVal = '0;
      v.expPcW = 1'b0;
      applyStimulus(v, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
# reg_bank

Architectural register storage for the ARM datapath: sixteen 32-bit registers R0–R15 with one general write port, a dedicated link-register write, and program-counter sequencing on R15. Sits directly upstream of the register read multiplexer. Drives all sixteen register values continuously as `regupdate_R0`..`regupdate_R15`, which the read multiplexer selects from.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: value loaded into R15 on reset.
- `PC_STEP`, 4: R15 increment per advancing cycle.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low (`reset == 0` resets on the next rising `clk`).
- `regWrite` in 1: general write enable.
- `writeRegister` in 4: general write destination index.
- `writeData` in 32: general write value.
- `linkWrite` in 1: write `linkData` into R14 (branch-with-link).
- `linkData` in 32: return address for R14.
- `pcAdvance` in 1: R15 advances by `PC_STEP` this cycle (deasserted during stall).
- `regupdate_R0`..`regupdate_R15` out 32 each: current register contents.
- `pcWritten` out 1: registered flag; high for one cycle after any cycle in which R15 was loaded by the general write port.

## Operation
- Reset (`reset == 0` at an edge): R0–R14 ← 0, R15 ← `RESET_PC`, `pcWritten` ← 0. Reset overrides every other input in the same cycle.
- General write: when `regWrite`, register `writeRegister` ← `writeData`.
- Link write: when `linkWrite`, R14 ← `linkData`.
- R15 update priority, highest first:
  - general write with `writeRegister == 15`: R15 ← `writeData`, `pcWritten` ← 1;
  - `pcAdvance`: R15 ← R15 + `PC_STEP`, modulo 2^32 (32'hFFFF_FFFC + 4 wraps to 0);
  - otherwise hold.
- R14 priority: general write to R14 beats `linkWrite` in the same cycle.
- Same-register conflicts have no other cases. Writes to different registers in one cycle both take effect.
- `regWrite` with `writeRegister != 15` clears `pcWritten` next cycle, as does any cycle without an R15 write.
- No read-during-write forwarding: outputs show the pre-edge value until the edge.

## Timing
- All outputs are registered. A write presented in cycle N is visible on `regupdate_Rx` in cycle N+1.
- `pcWritten` is asserted in cycle N+1 for an R15 write in cycle N.
- No handshake back-pressure. Every enabled write is accepted on the edge it is sampled.
- Reset asserted mid-stream discards any concurrent write. The first post-reset edge with `reset == 1` behaves normally.

## Configuration
- `REG_BANK_PC_INC_EN` defined:
  - R15 auto-increment is compiled in as described above.
- `REG_BANK_PC_INC_EN` undefined:
  - `pcAdvance` is ignored, and R15 changes only by reset or general write.
  - `pcWritten` behaviour is unchanged.

## Structure
- Shared package holds:
  - index constants `REG_SP = 4'd13`, `REG_LR = 4'd14`, `REG_PC = 4'd15`;
  - the 32-bit word type/width constant.
- `RESET_PC` and `PC_STEP` stay module parameters.
- Natural sub-module: `reg_cell`, a 32-bit register with synchronous active-low reset, load enable and reset value. It is instantiated sixteen times, with R14/R15 next-value muxing kept in `reg_bank`.

## Test plan
- Reset with `RESET_PC = 32'h0000_0100`: after one edge at `reset = 0`, R0–R14 = 0, R15 = 32'h100, `pcWritten = 0`.
- `regWrite = 1`, `writeRegister = 3`, `writeData = 32'hCCCC_CCCC`: R3 = 32'hCCCC_CCCC on the next cycle. All other registers unchanged.
- `pcAdvance` held 3 cycles from R15 = 32'h100: R15 reads 32'h104, 32'h108, 32'h10C. With macro undefined, R15 stays 32'h100.
- Same cycle: `pcAdvance = 1`, `regWrite = 1`, `writeRegister = 15`, `writeData = 32'h2000`: R15 = 32'h2000 (not 32'h2004), `pcWritten = 1` for exactly one cycle.
- Same cycle: `linkWrite = 1` with `linkData = 32'h44`, and `regWrite` to R14 with 32'h55: R14 = 32'h55. Repeat with `writeRegister = 2`: R14 = 32'h44, R2 = 32'h55.
- Wrap and reset-mid-write:
  - R15 = 32'hFFFF_FFFC with `pcAdvance`: R15 = 0.
  - `reset = 0` with `regWrite` to R5 = 32'hAAAA_AAAA: R5 = 0.
